ha_array_row_sequencer: RTL and testbench

//  Multi-cycle controller for the 8x8 unsigned approximate HA-array partial-product stage.
//  - Accepts one operand pair over a valid/ready handshake.
//  - Drives the pair onto an external ha_array instance.
//  - Folds the four row outputs (b/t pairs) into a 16-bit product through one shared adder, one row per cycle.
//  - Returns the product over a valid/ready handshake.
//  - Sits between the operand source and the result consumer; the reduction tree is replaced by a time-multiplexed accumulator.

---
 rtl/ha_array_row_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_ha_array_row_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ha_array_row_sequencer.sv
// ---------------------------------------------------------------------------
// ha_array_row_sequencer
//
// Multi-cycle controller for the 8x8 unsigned approximate HA-array
// partial-product stage. It takes one operand pair over a valid/ready
// handshake and drives it, registered, onto an external combinational
// ha_array instance. The four b/t row outputs are then folded into a 16-bit
// product through one shared adder, one row per cycle. The product is
// returned over a valid/ready handshake. This time-multiplexed accumulator
// replaces the usual reduction tree.
//
// Flow: IDLE -> LOAD -> ACC (NUM_ROWS cycles) -> DONE -> IDLE.
// If the accept happens at edge N, out_valid is high from the cycle after
// edge N+1+NUM_ROWS. A new operand pair can be accepted at most once every
// 7 cycles (default parameters).
//
// Ports
//   clk         in   1                   clock, rising edge
//   rst_n       in   1                   synchronous active-low reset
//   in_valid    in   1                   operand pair valid
//   in_ready    out  1                   high in IDLE only
//   in_x, in_y  in   8                   operands
//   arr_x,arr_y out  8                   registered operands to the ha_array
//   arr_b_flat  in   NUM_ROWS*ROW_B_W    row k b bus at [k*ROW_B_W +: ROW_B_W]
//   arr_t_flat  in   NUM_ROWS*ROW_T_W    row k t bus at [k*ROW_T_W +: ROW_T_W]
//   out_valid   out  1                   product valid (DONE)
//   out_ready   in   1                   consumer accepts the product
//   out_p       out  ACC_W               approximate product
//   busy        out  1                   high in LOAD, ACC and DONE
//
// Optional build macro ERR_STAT_EN adds the following ports:
//   err_abs     out  ACC_W               |x*y - out_p|, valid with out_valid
//   err_max     out  ACC_W               running max of err_abs over handshakes
//   err_clr     in   1                   clears err_max (wins over an update)
// ---------------------------------------------------------------------------
module ha_array_row_sequencer #(
  parameter int NUM_ROWS = 4,
  parameter int ROW_T_W  = 9,
  parameter int ROW_B_W  = 7,
  parameter int ACC_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_x,
  input  logic [7:0]                   in_y,
  output logic [7:0]                   arr_x,
  output logic [7:0]                   arr_y,
  input  logic [NUM_ROWS*ROW_B_W-1:0]  arr_b_flat,
  input  logic [NUM_ROWS*ROW_T_W-1:0]  arr_t_flat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_p,
  output logic                         busy
`ifdef ERR_STAT_EN
  ,
  output logic [ACC_W-1:0]             err_abs,
  output logic [ACC_W-1:0]             err_max,
  input  logic                         err_clr
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int ROW_IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  // b_k is shifted up by two before the add, so the row sum needs one bit
  // more than the wider of t and b<<2.
  localparam int RV_W = ((ROW_T_W > ROW_B_W + 2) ? ROW_T_W : ROW_B_W + 2) + 1;
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(NUM_ROWS - 1);

  logic [1:0]           state;
  logic [ROW_IDX_W-1:0] row_idx;
  logic [ACC_W-1:0]     acc;
  logic [ROW_T_W-1:0]   row_t;
  logic [ROW_B_W-1:0]   row_b;
  logic [ACC_W-1:0]     row_term;
  logic [ACC_W-1:0]     acc_next;

  // Products deliberately wrap modulo 2^ACC_W; there is no saturation.
  function automatic logic [ACC_W-1:0] acc_wrap(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
    return a + b;
  endfunction

  // row_val = t + (b << 2), placed at weight 2*k.
  function automatic logic [ACC_W-1:0] row_weigh(input logic [ROW_T_W-1:0]   t,
                                                 input logic [ROW_B_W-1:0]   b,
                                                 input logic [ROW_IDX_W-1:0] k);
    logic [RV_W-1:0] rv;
    rv = RV_W'(t) + (RV_W'(b) << 2);
    return ACC_W'(rv) << {k, 1'b0};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Row select: only the row addressed by row_idx feeds the shared adder.
  always_comb begin
    row_t = '0;
    row_b = '0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      if (row_idx == ROW_IDX_W'(k)) begin
        row_t = arr_t_flat[k*ROW_T_W +: ROW_T_W];
        row_b = arr_b_flat[k*ROW_B_W +: ROW_B_W];
      end
    end
  end

  assign row_term = row_weigh(row_t, row_b, row_idx);
  assign acc_next = acc_wrap(acc, row_term);

  // Control and visible outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_idx <= '0;
      out_p   <= '0;
      arr_x   <= '0;
      arr_y   <= '0;
    end else begin
      case (state)
        // IDLE: capture operands; they stay on the array until the next accept.
        IDLE: begin
          if (in_valid) begin
            arr_x <= in_x;
            arr_y <= in_y;
            state <= LOAD;
          end
        end
        // LOAD: one cycle for the combinational array to settle.
        LOAD: begin
          row_idx <= '0;
          state   <= ACC;
        end
        // ACC: fold one row per cycle; the last row goes directly to out_p.
        ACC: begin
          if (row_idx == LAST_ROW) begin
            out_p   <= acc_next;
            row_idx <= '0;
            state   <= DONE;
          end else begin
            row_idx <= row_idx + 1'b1;
          end
        end
        // DONE: hold out_p until the consumer takes it.
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accumulator datapath. It is cleared on accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      acc <= '0;
    end else if (state == ACC) begin
      acc <= acc_next;
    end
  end

`ifdef ERR_STAT_EN
  logic [15:0]      exact_prod;
  logic [ACC_W-1:0] exact_q;

  assign exact_prod = {8'd0, arr_x} * {8'd0, arr_y};

  // arr_x/arr_y are stable from LOAD onwards, so sample the exact product there.
  always_ff @(posedge clk) begin
    if (state == LOAD) exact_q <= ACC_W'(exact_prod);
  end

  assign err_abs = (exact_q >= out_p) ? (exact_q - out_p) : (out_p - exact_q);

  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      err_max <= '0;
    end else if (out_valid && out_ready && (err_abs > err_max)) begin
      err_max <= err_abs;
    end
  end
`endif

endmodule

// File: tb/tb_ha_array_row_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for ha_array_row_sequencer. A behavioural stand-in for the ha_array
// produces row buses from arr_x/arr_y in one of several modes:
//   0: exact split of x*y across rows 0 and 3, so out_p == x*y
//   1: every t_k = 1, b_k = 0
//   2: every t_k = 0, b_k = 7'h7F
//   3: t_k = k+1, b_k = k (distinct per row)
//   4: every t_k = 9'h1FF, b_k = 7'h7F (forces the 16-bit wrap)
// ---------------------------------------------------------------------------
module tb_ha_array_row_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x, in_y;
  logic [7:0]  arr_x, arr_y;
  logic [27:0] arr_b_flat;
  logic [35:0] arr_t_flat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        busy;
`ifdef ERR_STAT_EN
  logic [15:0] err_abs, err_max;
  logic        err_clr;
`endif

  int stub_mode;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ha_array_row_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .arr_x      (arr_x),
    .arr_y      (arr_y),
    .arr_b_flat (arr_b_flat),
    .arr_t_flat (arr_t_flat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .busy       (busy)
`ifdef ERR_STAT_EN
    ,
    .err_abs    (err_abs),
    .err_max    (err_max),
    .err_clr    (err_clr)
`endif
  );

  // Array stand-in.
  int stub_p, stub_r0, stub_r3, stub_q3;
  always_comb begin
    arr_b_flat = '0;
    arr_t_flat = '0;
    stub_p  = int'(arr_x) * int'(arr_y);
    stub_r0 = stub_p % 64;
    stub_r3 = stub_p / 64;
    stub_q3 = stub_r3 / 4;
    if (stub_q3 > 127) stub_q3 = 127;
    case (stub_mode)
      0: begin
        arr_b_flat[0 +: 7]  = 7'(stub_r0 / 4);
        arr_t_flat[0 +: 9]  = 9'(stub_r0 % 4);
        arr_b_flat[21 +: 7] = 7'(stub_q3);
        arr_t_flat[27 +: 9] = 9'(stub_r3 - 4 * stub_q3);
      end
      1: for (int k = 0; k < 4; k++) arr_t_flat[k*9 +: 9] = 9'd1;
      2: for (int k = 0; k < 4; k++) arr_b_flat[k*7 +: 7] = 7'h7F;
      3: for (int k = 0; k < 4; k++) begin
           arr_t_flat[k*9 +: 9] = 9'(k + 1);
           arr_b_flat[k*7 +: 7] = 7'(k);
         end
      4: for (int k = 0; k < 4; k++) begin
           arr_t_flat[k*9 +: 9] = 9'h1FF;
           arr_b_flat[k*7 +: 7] = 7'h7F;
         end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int          mode;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] exp_p;
  } vec_t;

  vec_t vecs[10];
  int   max_model = 0;

  initial begin
    vecs[0] = '{0, 8'd255, 8'd255, 16'd65025};
    vecs[1] = '{0, 8'd0,   8'd0,   16'd0};
    vecs[2] = '{0, 8'd13,  8'd17,  16'd221};
    vecs[3] = '{0, 8'd200, 8'd150, 16'd30000};
    vecs[4] = '{0, 8'd1,   8'd255, 16'd255};
    vecs[5] = '{0, 8'd128, 8'd2,   16'd256};
    vecs[6] = '{1, 8'd200, 8'd150, 16'd85};
    vecs[7] = '{2, 8'd3,   8'd5,   16'd43180};
    vecs[8] = '{3, 8'd7,   8'd9,   16'd1225};
    vecs[9] = '{4, 8'd255, 8'd1,   16'd21079};

    stub_mode = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
`ifdef ERR_STAT_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p",     out_p,     0);
    chk("rst_arr_x",     arr_x,     0);
    chk("rst_arr_y",     arr_y,     0);
    chk("rst_busy",      busy,      0);
`ifdef ERR_STAT_EN
    chk("rst_err_max",   err_max,   0);
`endif
    rst_n = 1'b1;

    // Table-driven transactions with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      int lat;
      @(negedge clk);
      stub_mode = vecs[i].mode;
      in_x = vecs[i].x; in_y = vecs[i].y; in_valid = 1'b1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(posedge clk);                       // accept edge N
      @(negedge clk);
      in_valid = 1'b0; in_x = 8'hA5; in_y = 8'h5A;
      chk($sformatf("v%0d_arr_x", i), arr_x, vecs[i].x);
      chk($sformatf("v%0d_arr_y", i), arr_y, vecs[i].y);
      chk($sformatf("v%0d_busy", i),  busy,  1);
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk); @(negedge clk); lat++;
      end
      // out_valid rises after edge N+5; the product is taken at edge N+6.
      chk($sformatf("v%0d_latency", i), lat, 5);
      chk($sformatf("v%0d_out_p", i), out_p, vecs[i].exp_p);
`ifdef ERR_STAT_EN
      begin
        int ex, e;
        ex = int'(vecs[i].x) * int'(vecs[i].y);
        e  = (ex >= int'(vecs[i].exp_p)) ? ex - int'(vecs[i].exp_p) : int'(vecs[i].exp_p) - ex;
        chk($sformatf("v%0d_err_abs", i), err_abs, e);
        if (e > max_model) max_model = e;
      end
`endif
      @(posedge clk);                       // handshake
      @(negedge clk);
      chk($sformatf("v%0d_post_valid", i), out_valid, 0);
      chk($sformatf("v%0d_post_ready", i), in_ready, 1);
`ifdef ERR_STAT_EN
      chk($sformatf("v%0d_err_max", i), err_max, max_model);
`endif
    end

    // Back-pressure: DONE held for 10 cycles while a new request is offered.
    begin
      int w;
      stub_mode = 1; in_x = 8'd10; in_y = 8'd20; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 20) begin
        @(posedge clk); @(negedge clk); w++;
      end
      chk("stall_reach_done", w, 5);
      for (int c = 0; c < 10; c++) begin
        in_valid = 1'b1; in_x = 8'd99; in_y = 8'd98;
        chk($sformatf("stall%0d_valid", c), out_valid, 1);
        chk($sformatf("stall%0d_p", c),     out_p,     85);
        chk($sformatf("stall%0d_ready", c), in_ready,  0);
        @(posedge clk); @(negedge clk);
      end
      chk("stall_arr_x", arr_x, 10);
      chk("stall_arr_y", arr_y, 20);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("stall_release_valid", out_valid, 0);
      chk("stall_release_ready", in_ready,  1);
      chk("stall_no_capture",    arr_x,     10);
    end

    // Issue interval with in_valid held high: in_ready recurs every 7 cycles.
    begin
      int gap;
      stub_mode = 3; in_x = 8'd1; in_y = 8'd2; in_valid = 1'b1;
      chk("ii_start_ready", in_ready, 1);
      gap = 0;
      do begin
        @(negedge clk); gap++;
      end while (!in_ready && gap < 30);
      in_valid = 1'b0;
      chk("issue_interval", gap, 7);
    end

`ifdef ERR_STAT_EN
    @(negedge clk);
    chk("pre_clr_err_max_nonzero", (err_max != 0), 1);
    err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", err_max, 0);
`endif

    // Reset during ACC row 2: no stale product may appear afterwards.
    begin
      int seen;
      @(negedge clk);
      stub_mode = 0; in_x = 8'd255; in_y = 8'd255; in_valid = 1'b1;
      @(posedge clk);                       // accept edge N
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);            // N+3: now folding row 2
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_in_ready",  in_ready,  1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy",      busy,      0);
      chk("midrst_out_p",     out_p,     0);
      chk("midrst_arr_x",     arr_x,     0);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); @(negedge clk);
        if (out_valid || busy) seen++;
      end
      chk("midrst_no_stale", seen, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
